// File: rtl/lampfpu_sqrt_sched_pkg.sv
// Shared types for the sqrt scheduler: request payload, FSM states, ID width helper.
package lampfpu_sqrt_sched_pkg;

    localparam int unsigned SQRT_REQ_W = 22;

    typedef struct packed {
        logic       invSqrt;
        logic       sign;
        logic [7:0] exp;
        logic [7:0] extMant;
        logic       isInf;
        logic       isZero;
        logic       isSNAN;
        logic       isQNAN;
    } sqrt_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } sqrt_sched_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lampfpu_sqrt_sched_rr_arb.sv
// Combinational round-robin arbiter: first valid requester at or after the pointer, with wrap.
module lampfpu_sqrt_sched_rr_arb
    import lampfpu_sqrt_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_idx;

    // Walk from the farthest candidate back to the pointer so the nearest valid one wins.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_gnt_oh  = NUM_REQ'(1) << w_idx;
                o_gnt_idx = w_idx;
                o_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lampfpu_sqrt_sched.sv
// Shares one multi-cycle sqrt unit between NUM_REQ requesters: round-robin accept,
// operand hold, result capture with requester tag, and a watchdog abort.
module lampfpu_sqrt_sched
    import lampfpu_sqrt_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ID_W        = id_width(NUM_REQ),
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*SQRT_REQ_W-1:0]  req_op_i,
    output logic                           doSqrt_o,
    output logic                           invSqrt_o,
    output logic                           signum_o,
    output logic                           isInf_o,
    output logic                           isZero_o,
    output logic                           isSNAN_o,
    output logic                           isQNAN_o,
    output logic [7:0]                     extExp_o,
    output logic [7:0]                     extMant_o,
    input  logic                           valid_i,
    input  logic                           s_res_i,
    input  logic [7:0]                     e_res_i,
    input  logic [11:0]                    f_res_i,
    input  logic                           isToRound_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic                           rsp_s_o,
    output logic [7:0]                     rsp_e_o,
    output logic [11:0]                    rsp_f_o,
    output logic                           rsp_isToRound_o,
    output logic                           rsp_err_o,
    output logic                           busy_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;

    sqrt_sched_state_t r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    sqrt_req_t         r_op;
    logic [WD_W-1:0]   r_wd;
    logic              r_do_sqrt;
    logic              r_rsp_valid;
    logic              r_rsp_s;
    logic [7:0]        r_rsp_e;
    logic [11:0]       r_rsp_f;
    logic              r_rsp_rnd;
    logic              r_rsp_err;

    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_any;
    sqrt_req_t          w_sel_op;

    lampfpu_sqrt_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req     (req_valid_i),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Operand of the granted requester.
    always_comb begin
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_op = req_op_i[i*SQRT_REQ_W +: SQRT_REQ_W];
            end
        end
    end

    assign w_ptr_nxt   = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    assign req_ready_o = (r_state == ST_IDLE && !rst) ? w_gnt_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_wd        <= '0;
            r_do_sqrt   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_s     <= 1'b0;
            r_rsp_e     <= '0;
            r_rsp_f     <= '0;
            r_rsp_rnd   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_do_sqrt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op      <= w_sel_op;
                        r_id      <= w_gnt_idx;
                        r_ptr     <= w_ptr_nxt;
                        r_do_sqrt <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    r_wd <= r_wd + WD_W'(1);
                    // A result arriving in the final watchdog cycle still counts as good.
                    if (valid_i) begin
                        r_rsp_s     <= s_res_i;
                        r_rsp_e     <= e_res_i;
                        r_rsp_f     <= f_res_i;
                        r_rsp_rnd   <= isToRound_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_rsp_s     <= 1'b0;
                        r_rsp_e     <= '0;
                        r_rsp_f     <= '0;
                        r_rsp_rnd   <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign doSqrt_o        = r_do_sqrt;
    assign invSqrt_o       = r_op.invSqrt;
    assign signum_o        = r_op.sign;
    assign extExp_o        = r_op.exp;
    assign extMant_o       = r_op.extMant;
    assign isInf_o         = r_op.isInf;
    assign isZero_o        = r_op.isZero;
    assign isSNAN_o        = r_op.isSNAN;
    assign isQNAN_o        = r_op.isQNAN;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_id_o        = r_id;
    assign rsp_s_o         = r_rsp_s;
    assign rsp_e_o         = r_rsp_e;
    assign rsp_f_o         = r_rsp_f;
    assign rsp_isToRound_o = r_rsp_rnd;
    assign rsp_err_o       = r_rsp_err;
    assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
// Scoreboard bench for lampfpu_sqrt_sched with a fixed-latency sqrt stub.
module tb_lampfpu_sqrt_sched;
    import lampfpu_sqrt_sched_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;
    localparam int unsigned OPW  = NREQ * SQRT_REQ_W;

    typedef struct packed {
        logic [7:0]  id;
        logic        s;
        logic [7:0]  e;
        logic [11:0] f;
        logic        rnd;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid_i, req_ready_o;
    logic [OPW-1:0]  req_op_i;
    logic            doSqrt_o, invSqrt_o, signum_o, isInf_o, isZero_o, isSNAN_o, isQNAN_o;
    logic [7:0]      extExp_o, extMant_o;
    logic            valid_i, s_res_i, isToRound_i;
    logic [7:0]      e_res_i;
    logic [11:0]     f_res_i;
    logic            rsp_valid_o, rsp_ready_i;
    logic [IDW-1:0]  rsp_id_o;
    logic            rsp_s_o, rsp_isToRound_o, rsp_err_o, busy_o;
    logic [7:0]      rsp_e_o;
    logic [11:0]     rsp_f_o;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = -100;
    int   n_out = 0;
    int   m_ptr = 0;
    int   m_g;
    logic exp_err;
    exp_t sb_q[$];
    exp_t m_ex;
    sqrt_req_t m_op;
    logic [NREQ-1:0] m_acc;

    logic st_valid, st_run, inj_valid, stub_en;
    int   st_cnt, stub_lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lampfpu_sqrt_sched #(.NUM_REQ(NREQ), .ID_W(IDW), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .doSqrt_o(doSqrt_o), .invSqrt_o(invSqrt_o), .signum_o(signum_o),
        .isInf_o(isInf_o), .isZero_o(isZero_o), .isSNAN_o(isSNAN_o), .isQNAN_o(isQNAN_o),
        .extExp_o(extExp_o), .extMant_o(extMant_o), .valid_i(valid_i), .s_res_i(s_res_i),
        .e_res_i(e_res_i), .f_res_i(f_res_i), .isToRound_i(isToRound_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_s_o(rsp_s_o), .rsp_e_o(rsp_e_o), .rsp_f_o(rsp_f_o),
        .rsp_isToRound_o(rsp_isToRound_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Stub result: e = exp/2 + 0x40, f = extMant scaled into 12 bits.
    function automatic logic [7:0] mdl_e(input logic [7:0] x);
        return 8'({1'b0, x[7:1]} + 8'h40);
    endfunction
    function automatic logic [11:0] mdl_f(input logic [7:0] m);
        return {1'b0, m, 3'b000};
    endfunction
    function automatic sqrt_req_t mk_op(input logic inv, input logic s, input logic [7:0] e,
                                        input logic [7:0] m);
        sqrt_req_t o;
        o = '0;
        o.invSqrt = inv;
        o.sign    = s;
        o.exp     = e;
        o.extMant = m;
        return o;
    endfunction
    function automatic logic bit_at(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction
    function automatic sqrt_req_t get_slot(input logic [OPW-1:0] v, input int i);
        logic [OPW-1:0] t;
        t = v >> (i * SQRT_REQ_W);
        return t[SQRT_REQ_W-1:0];
    endfunction

    // Fixed-latency sqrt stub; reads the held operands at result time.
    always @(posedge clk) begin
        if (rst) begin
            st_valid <= 1'b0;
            st_run   <= 1'b0;
            st_cnt   <= 0;
        end else begin
            st_valid <= 1'b0;
            if (doSqrt_o && stub_en) begin
                st_run <= 1'b1;
                st_cnt <= 1;
            end else if (st_run) begin
                if (st_cnt == stub_lat - 1) begin
                    st_valid <= 1'b1;
                    st_run   <= 1'b0;
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end
        end
    end
    assign valid_i     = st_valid | inj_valid;
    assign s_res_i     = st_valid & signum_o;
    assign isToRound_i = st_valid & invSqrt_o;
    assign e_res_i     = st_valid ? mdl_e(extExp_o) : 8'h00;
    assign f_res_i     = st_valid ? mdl_f(extMant_o) : 12'h000;

    // Monitor: predicts grants, pushes expected responses, pops and compares on handshake.
    always @(negedge clk) begin
        if (rst) begin
            m_ptr = 0;
            n_out = 0;
            sb_q.delete();
        end else begin
            m_acc = req_ready_o & req_valid_i;
            if (m_acc != '0) begin
                m_g = 0;
                for (int k = NREQ - 1; k >= 0; k--)
                    if (bit_at(32'(req_valid_i), (m_ptr + k) % NREQ)) m_g = (m_ptr + k) % NREQ;
                chk("grant", 32'(m_acc), 32'(1) << m_g);
                chk("outstanding", n_out, 0);
                m_op = get_slot(req_op_i, m_g);
                m_ex = '0;
                m_ex.id = 8'(m_g);
                if (exp_err) begin
                    m_ex.err = 1'b1;
                end else begin
                    m_ex.s   = m_op.sign;
                    m_ex.e   = mdl_e(m_op.exp);
                    m_ex.f   = mdl_f(m_op.extMant);
                    m_ex.rnd = m_op.invSqrt;
                end
                sb_q.push_back(m_ex);
                n_out++;
                m_ptr   = (m_g + 1) % NREQ;
                acc_cyc = cyc;
            end
            if (doSqrt_o) chk("dosqrt_after_accept", cyc - acc_cyc, 1);
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid_o), 0);
                end else begin
                    m_ex = sb_q.pop_front();
                    chk("rsp_id", 32'(rsp_id_o), 32'(m_ex.id));
                    chk("rsp_s", 32'(rsp_s_o), 32'(m_ex.s));
                    chk("rsp_e", 32'(rsp_e_o), 32'(m_ex.e));
                    chk("rsp_f", 32'(rsp_f_o), 32'(m_ex.f));
                    chk("rsp_rnd", 32'(rsp_isToRound_o), 32'(m_ex.rnd));
                    chk("rsp_err", 32'(rsp_err_o), 32'(m_ex.err));
                    n_out--;
                end
            end
        end
    end

    task automatic set_op(input int idx, input sqrt_req_t op);
        logic [OPW-1:0] msk;
        logic [OPW-1:0] val;
        msk = OPW'({SQRT_REQ_W{1'b1}}) << (idx * SQRT_REQ_W);
        val = OPW'(op) << (idx * SQRT_REQ_W);
        req_op_i = (req_op_i & ~msk) | val;
    endtask

    task automatic do_req(input int idx, input sqrt_req_t op);
        bit ok;
        ok = 1'b0;
        set_op(idx, op);
        req_valid_i = req_valid_i | (NREQ'(1) << idx);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bit_at(32'(req_ready_o), idx)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("req_accept", 32'(bit_at(32'(req_ready_o), idx)), 1);
        @(posedge clk); #1;
        req_valid_i = req_valid_i & ~(NREQ'(1) << idx);
    endtask

    // Returns at the negedge of the first response-valid cycle.
    task automatic wait_rsp(input logic [15:0] hold, output int n);
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                n = c;
                break;
            end
            if (busy_o) chk("op_hold", {extExp_o, extMant_o}, hold);
            @(posedge clk); #1;
        end
        if (n == 0) chk("rsp_wait", 32'(rsp_valid_o), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation stalled at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, k;
        logic [NREQ-1:0] a;
        logic            glog[4];
        sqrt_req_t       lop;
        rst = 1'b1; req_valid_i = '0; req_op_i = '0; rsp_ready_i = 1'b1;
        inj_valid = 1'b0; stub_en = 1'b1; stub_lat = 10; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_dosqrt", 32'(doSqrt_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_operand", {extExp_o, extMant_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request on requester 0: 4.0
        do_req(0, mk_op(1'b0, 1'b0, 8'h81, 8'h80));
        wait_rsp(16'h8180, n);
        chk("t1_latency", n, 12);
        chk("t1_e", 32'(rsp_e_o), 32'h80);
        chk("t1_f", 32'(rsp_f_o), 32'h400);
        chk("t1_id", 32'(rsp_id_o), 0);
        chk("t1_err", 32'(rsp_err_o), 0);
        @(posedge clk); #1;

        // Both requesters valid continuously: alternate grants.
        do_reset();
        set_op(0, mk_op(1'b0, 1'b0, 8'h81, 8'h80));
        set_op(1, mk_op(1'b1, 1'b1, 8'h90, 8'hA5));
        req_valid_i = '1;
        k = 0;
        lop = '0;
        for (int c = 0; c < 400 && k < 4; c++) begin
            @(negedge clk);
            a = req_ready_o & req_valid_i;
            if (a != '0) begin
                glog[k] = a[1];
                lop = get_slot(req_op_i, a[1] ? 1 : 0);
                k++;
            end
            @(posedge clk); #1;
            if (a[0]) set_op(0, mk_op(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom)));
            if (a[1]) set_op(1, mk_op(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom)));
            if (k == 4) req_valid_i = '0;
        end
        req_valid_i = '0;
        if (k < 4) chk("t2_accepts", k, 4);
        for (int j = 0; j < 4; j++) chk("t2_order", 32'(glog[j]), 32'(j % 2));
        wait_rsp({lop.exp, lop.extMant}, n);
        chk("t2_latency", n, 12);
        @(posedge clk); #1;

        // Response back-pressure for 20 cycles.
        rsp_ready_i = 1'b0;
        do_req(0, mk_op(1'b0, 1'b1, 8'h7E, 8'hC3));
        wait_rsp(16'h7EC3, n);
        @(posedge clk); #1;
        set_op(1, mk_op(1'b1, 1'b0, 8'h85, 8'h91));
        req_valid_i = 2'b10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_valid", 32'(rsp_valid_o), 1);
            chk("t3_e", 32'(rsp_e_o), 32'h7F);
            chk("t3_f", 32'(rsp_f_o), 32'h618);
            chk("t3_s", 32'(rsp_s_o), 1);
            chk("t3_ready", 32'(req_ready_o), 0);
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_hs_ready", 32'(req_ready_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_idle_busy", 32'(busy_o), 0);
        chk("t3_idle_ready", 32'(req_ready_o), 32'h2);
        @(posedge clk); #1;
        req_valid_i = '0;
        wait_rsp(16'h8591, n);
        chk("t3_latency", n, 12);
        @(posedge clk); #1;

        // Watchdog abort, then a late valid_i while idle.
        stub_en = 1'b0;
        exp_err = 1'b1;
        do_req(1, mk_op(1'b1, 1'b1, 8'h81, 8'h80));
        wait_rsp(16'h8180, n);
        chk("t4_latency", n, 66);
        chk("t4_err", 32'(rsp_err_o), 1);
        chk("t4_fields", {rsp_s_o, rsp_e_o, rsp_f_o, rsp_isToRound_o}, 0);
        @(posedge clk); #1;
        exp_err = 1'b0;
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_ghost_valid", 32'(rsp_valid_o), 0);
            chk("t4_ghost_busy", 32'(busy_o), 0);
            @(posedge clk); #1;
        end
        stub_en = 1'b1;

        // Reset five cycles into BUSY; pointer must return to 0.
        do_req(0, mk_op(1'b0, 1'b0, 8'h81, 8'h80));
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_rsp", {rsp_valid_o, rsp_err_o, rsp_s_o, rsp_e_o, rsp_f_o, rsp_isToRound_o}, 0);
        chk("t5_operand", {doSqrt_o, extExp_o, extMant_o, signum_o, invSqrt_o}, 0);
        chk("t5_ready", 32'(req_ready_o), 0);
        @(posedge clk); #1;
        set_op(0, mk_op(1'b0, 1'b0, 8'h81, 8'h80));
        set_op(1, mk_op(1'b0, 1'b1, 8'h70, 8'h99));
        req_valid_i = '1;
        a = '0;
        for (int c = 0; c < 20 && a == '0; c++) begin
            @(negedge clk);
            a = req_ready_o & req_valid_i;
            @(posedge clk); #1;
        end
        req_valid_i = '0;
        chk("t5_grant_after_rst", 32'(a), 1);
        wait_rsp(16'h8180, n);
        chk("t5_latency", n, 12);
        @(posedge clk); #1;

        // valid_i in the last watchdog cycle wins over the abort.
        stub_lat = 64;
        do_req(1, mk_op(1'b1, 1'b0, 8'h81, 8'h80));
        wait_rsp(16'h8180, n);
        chk("t6_latency", n, 66);
        chk("t6_err", 32'(rsp_err_o), 0);
        chk("t6_e", 32'(rsp_e_o), 32'h80);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lampfpu_sqrt_sched.md
Name: lampFPU_sqrt_sched

Overview:
Round-robin scheduler that shares one lampFPU_sqrt instance (sqrt / inverse-sqrt, multi-cycle, single operation in flight) between NUM_REQ requesters. It accepts one request at a time over valid/ready, holds the operands stable on the unit's inputs for the whole operation, and pulses doSqrt. It then captures the unit's one-cycle valid result and returns it, tagged with the requester ID, over a single valid/ready response channel. A watchdog aborts operations that never complete.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester ID tag
TIMEOUT_CYC, 64, maximum cycles from the doSqrt pulse to valid_i before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_op_i  in  NUM_REQ*22  packed sqrt_req_t per requester: invSqrt, sign, exp[8], extMant[8], isInf, isZero, isSNAN, isQNAN
doSqrt_o  out  1  one-cycle start pulse to the sqrt unit
invSqrt_o, signum_o, isInf_o, isZero_o, isSNAN_o, isQNAN_o  out  1 each  held operand fields
extExp_o  out  8  held exponent
extMant_o  out  8  held extended mantissa
valid_i  in  1  unit result valid (one-cycle pulse)
s_res_i  in  1  unit result sign
e_res_i  in  8  unit result exponent
f_res_i  in  12  unit result significand
isToRound_i  in  1  unit rounding request
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  ID of the granted requester
rsp_s_o  out  1  captured result sign
rsp_e_o  out  8  captured result exponent
rsp_f_o  out  12  captured result significand
rsp_isToRound_o  out  1  captured rounding request
rsp_err_o  out  1  1 = operation aborted by the watchdog
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - Round-robin pointer = 0.
  - Operand registers = 0.
  - Watchdog counter = 0.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE arbitration:
  - Grant the first i with req_valid_i[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready_o[grant]=1 combinationally (in IDLE only). All other ready bits are 0.
  - On handshake: register the operand and the grant ID, set rr_ptr = grant+1 (mod NUM_REQ), go to ISSUE.
  - No valid request: stay in IDLE, all ready bits 0.
- ISSUE:
  - doSqrt_o=1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to BUSY.
- Operand hold: the operand outputs hold the registered values from ISSUE until the exit from BUSY. The unit samples its flags a cycle late and reads the exponent at result time, so these outputs must not change in ISSUE or BUSY.
- BUSY:
  - Increment the watchdog counter every cycle.
  - On valid_i=1: capture s/e/f/isToRound into the response registers, rsp_err=0, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYC-1: response fields = 0, rsp_err=1, go to RESP.
  - If valid_i arrives in that same last cycle, valid_i wins.
- RESP:
  - rsp_valid_o=1, with all rsp_* fields stable until rsp_ready_i=1.
  - On the rsp_ready_i handshake go to IDLE. No request is accepted in that same cycle.
- valid_i outside BUSY (late pulse after a timeout, or a spurious pulse) is ignored and never creates a response.
- Latency: request handshake at cycle T → doSqrt at T+1 → response valid the cycle after valid_i. Minimum issue interval = unit latency + 3 cycles.
- Requester obligations: req_valid_i may drop without handshake (no deadlock). Requesters keep req_op_i stable only while valid and not yet accepted.
- Reset mid-operation: the scheduler returns to IDLE and drops any pending response. The sqrt unit shares rst.
- NUM_REQ=1: the pointer is constant 0 and rsp_id_o is always 0.

Decomposition:
- lampFPU_pkg gains:
  - sqrt_req_t, the packed 22-bit struct in the field order listed under req_op_i.
  - The state enum sqrt_sched_state_t.
  - SQRT_REQ_W=22.
- Sub-module lampFPU_rr_arb(NUM_REQ): combinational round-robin grant from req vector and pointer, outputs one-hot grant, grant index and any-valid.

Test Plan:
All scenarios use a stub sqrt unit with fixed latency 10 that returns e=0x80, f=0x400 for input exp=0x81, extMant=0x80.
- Single request on requester 0 (4.0: exp=0x81, extMant=0x80, invSqrt=0) → doSqrt one cycle after accept; rsp_valid_o 11 cycles after doSqrt; rsp_id=0, rsp_e=0x80, rsp_f=0x400, rsp_err=0. extExp_o stays 0x81 throughout BUSY.
- Both requesters valid continuously, 4 operations → grant order 0,1,0,1; never two accepts without an intervening response handshake.
- rsp_ready_i held low for 20 cycles → rsp_* stable and req_ready_o all 0 throughout; IDLE entered only after the handshake.
- Stub never asserts valid → rsp_err=1 and rsp fields 0 after 64 BUSY cycles. A late valid_i injected in IDLE produces no response.
- rst asserted 5 cycles into BUSY → next cycle all outputs 0, state IDLE, rr_ptr=0. A new request then completes normally.
- valid_i coinciding with the last watchdog cycle → normal result, rsp_err=0.
